f_to_d_queue: RTL

- Parametrised fetch-to-decode buffer. Successor to the single-entry F->D pipeline register.
- Decouples fetch from decode with a DEPTH-entry circular FIFO of {pc, inst, bp_taken, bp_target_pc} packets.
- Fetch pushes through a valid/ready handshake. Decode pops unless stall_D or MEM_stall is asserted.
- EX_taken (branch mispredict/redirect) flushes every buffered packet in one cycle.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/f_to_d_queue_if.sv | 45 ++++
 rtl/fq_storage.sv | 27 ++
 rtl/f_to_d_queue.sv | 109 ++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch-to-decode path: the decode NOP and the
// layout of a fetch packet when it is flattened into one storage word.
package pipe_pkg;

  // Widths used when a block is instantiated without overrides.
  localparam int XLEN_DEF    = 32;
  localparam int PC_BITS_DEF = 12;
  localparam int DEPTH_DEF   = 4;

  // addi r0,r0,0 -- what decode sees when there is no fetched instruction.
  localparam logic [31:0] NOP_INST = 32'h2000_0000;

  // Packet layout, MSB to LSB: {pc, inst, bp_taken, bp_target_pc}.
  function automatic int pkt_width(input int xlen, input int pc_bits);
    return pc_bits + xlen + 1 + pc_bits;
  endfunction

  function automatic int off_bp_target(input int pc_bits);
    return 0 * pc_bits;
  endfunction

  function automatic int off_bp_taken(input int pc_bits);
    return pc_bits;
  endfunction

  function automatic int off_inst(input int pc_bits);
    return pc_bits + 1;
  endfunction

  function automatic int off_pc(input int xlen, input int pc_bits);
    return pc_bits + 1 + xlen;
  endfunction

endpackage

// File: rtl/f_to_d_queue_if.sv
// Fetch/decode handshake bundle around the fetch-to-decode queue.
// master: the pipeline side (fetch drives packets, decode/EX drive control).
// slave:  the queue itself.
interface f_to_d_queue_if #(
  parameter int XLEN    = 32,
  parameter int PC_BITS = 12,
  parameter int DEPTH   = 4
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  // Fetch side
  logic               F_valid;
  logic [PC_BITS-1:0] F_pc;
  logic [XLEN-1:0]    F_inst;
  logic               F_BP_taken;
  logic [PC_BITS-1:0] F_BP_target_pc;
  logic               F_ready;

  // Pipeline control
  logic               stall_D;
  logic               MEM_stall;
  logic               EX_taken;

  // Decode side
  logic               D_valid;
  logic [PC_BITS-1:0] D_pc;
  logic [XLEN-1:0]    D_inst;
  logic               D_BP_taken;
  logic [PC_BITS-1:0] D_BP_target_pc;
  logic [CNT_W-1:0]   count;

  modport master (
    output F_valid, F_pc, F_inst, F_BP_taken, F_BP_target_pc,
    output stall_D, MEM_stall, EX_taken,
    input  F_ready, D_valid, D_pc, D_inst, D_BP_taken, D_BP_target_pc, count
  );

  modport slave (
    input  F_valid, F_pc, F_inst, F_BP_taken, F_BP_target_pc,
    input  stall_D, MEM_stall, EX_taken,
    output F_ready, D_valid, D_pc, D_inst, D_BP_taken, D_BP_target_pc, count
  );

endinterface

// File: rtl/fq_storage.sv
// Packet storage for the fetch-to-decode queue: one synchronous write port,
// one asynchronous read port so the head is visible in the same cycle.
module fq_storage #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 57,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the incoming packet into its slot.
  // NOTE: the array has no reset -- the occupancy counter decides which slots
  // are meaningful, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/f_to_d_queue.sv
// Fetch-to-decode buffer: DEPTH-entry circular FIFO of fetch packets.
// Fetch pushes on F_valid & F_ready, decode pops the head unless stalled,
// and an EX redirect empties the queue in a single cycle.
module f_to_d_queue
  import pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int PC_BITS = PC_BITS_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input logic          clk,
  input logic          rst,
  f_to_d_queue_if.slave fd
);

  localparam int CNT_W     = $clog2(DEPTH + 1);
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int PKT_W     = pkt_width(XLEN, PC_BITS);
  localparam int OFF_TGT   = off_bp_target(PC_BITS);
  localparam int OFF_TAKEN = off_bp_taken(PC_BITS);
  localparam int OFF_INST  = off_inst(PC_BITS);
  localparam int OFF_PC    = off_pc(XLEN, PC_BITS);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;

  logic             ready;
  logic             head_valid;
  logic             enq;
  logic             deq;
  logic             wr_en;
  logic [PKT_W-1:0] wr_pkt;
  logic [PKT_W-1:0] head_pkt;

  // NOTE: ready and head_valid come straight from the counter register, so
  // fetch never sees a combinational path from a stall or a pop; a pop from
  // a full queue re-opens F_ready only on the following cycle.
  assign ready      = (count_q != FULL_CNT);
  assign head_valid = (count_q != '0);

  assign enq = fd.F_valid & ready;
  assign deq = head_valid & ~fd.stall_D & ~fd.MEM_stall;

  // A redirect drops a packet presented in the same cycle.
  assign wr_en  = enq & ~fd.EX_taken;
  assign wr_pkt = {fd.F_pc, fd.F_inst, fd.F_BP_taken, fd.F_BP_target_pc};

  fq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (PKT_W),
    .ADDR_W(PTR_W)
  ) u_storage (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr),
    .wdata(wr_pkt),
    .raddr(rd_ptr),
    .rdata(head_pkt)
  );

  // Pointer and occupancy update: flush first, then independent push/pop.
  // Pointers are PTR_W bits wide, so with a power-of-two DEPTH they wrap on
  // their own and fullness is judged from the counter alone.
  // NOTE: sequential state uses non-blocking assignments so every register
  // in this block samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (fd.EX_taken) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Present the head packet, or a NOP bubble when the queue is empty.
  // NOTE: every output gets its idle value before the if, so no path through
  // this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    fd.D_pc           = '0;
    fd.D_inst         = XLEN'(NOP_INST);
    fd.D_BP_taken     = 1'b0;
    fd.D_BP_target_pc = '0;
    if (head_valid) begin
      fd.D_pc           = head_pkt[OFF_PC +: PC_BITS];
      fd.D_inst         = head_pkt[OFF_INST +: XLEN];
      fd.D_BP_taken     = head_pkt[OFF_TAKEN];
      fd.D_BP_target_pc = head_pkt[OFF_TGT +: PC_BITS];
    end
  end

  assign fd.D_valid = head_valid;
  assign fd.F_ready = ready;
  assign fd.count   = count_q;

endmodule
